// File: rtl/dt_tree_engine_pkg.sv
// Shared definitions for the decision-tree engine: default sizes, node-word layout,
// walker state encoding and a node-word packing helper.
package dt_tree_engine_pkg;

   localparam int DEF_NUM_FEAT  = 64;
   localparam int DEF_FEAT_W    = 12;
   localparam int DEF_NUM_NODES = 32;
   localparam int DEF_CLASS_W   = 2;
   localparam int DEF_MAX_DEPTH = 16;

   localparam int DT_FIDX_W = $clog2(DEF_NUM_FEAT);
   localparam int DT_NODE_W = $clog2(DEF_NUM_NODES);
   localparam int DT_WORD_W = 1 + DT_FIDX_W + DEF_FEAT_W + 2 * DT_NODE_W;

   // Node word is {leaf, fidx, thresh, left, right}, right child in the LSBs.
   localparam int DT_RIGHT_LSB = 0;
   localparam int DT_LEFT_LSB  = DT_NODE_W;
   localparam int DT_THR_LSB   = 2 * DT_NODE_W;
   localparam int DT_FIDX_LSB  = DT_THR_LSB + DEF_FEAT_W;
   localparam int DT_LEAF_POS  = DT_FIDX_LSB + DT_FIDX_W;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WALK,
      ST_DONE
   } state_t;

   function automatic logic [DT_WORD_W-1:0] pack_node(
      input logic                  leaf,
      input logic [DT_FIDX_W-1:0]  fidx,
      input logic [DEF_FEAT_W-1:0] thresh,
      input logic [DT_NODE_W-1:0]  left,
      input logic [DT_NODE_W-1:0]  right
   );
      return {leaf, fidx, thresh, left, right};
   endfunction

endpackage

// File: rtl/dt_tree_engine_if.sv
// Configuration and classification bundle between the feature source and the tree engine.
interface dt_tree_engine_if
   import dt_tree_engine_pkg::*;
#(
   parameter int NUM_FEAT  = DEF_NUM_FEAT,
   parameter int FEAT_W    = DEF_FEAT_W,
   parameter int NUM_NODES = DEF_NUM_NODES,
   parameter int CLASS_W   = DEF_CLASS_W,
   parameter int MAX_DEPTH = DEF_MAX_DEPTH
);
   localparam int FIDX_W  = $clog2(NUM_FEAT);
   localparam int NODE_W  = $clog2(NUM_NODES);
   localparam int WORD_W  = 1 + FIDX_W + FEAT_W + 2 * NODE_W;
   localparam int DEPTH_W = $clog2(MAX_DEPTH + 1);

   logic                       cfg_we;
   logic [NODE_W-1:0]          cfg_addr;
   logic [WORD_W-1:0]          cfg_data;
   logic                       cfg_err;
   logic [NUM_FEAT*FEAT_W-1:0] features;
   logic                       start;
   logic                       ready;
   logic [CLASS_W-1:0]         class_out;
   logic                       result_valid;
   logic                       err_out;
   logic [DEPTH_W-1:0]         depth_out;

   modport master (
      output cfg_we, cfg_addr, cfg_data, features, start,
      input  cfg_err, ready, class_out, result_valid, err_out, depth_out
   );

   modport slave (
      input  cfg_we, cfg_addr, cfg_data, features, start,
      output cfg_err, ready, class_out, result_valid, err_out, depth_out
   );

endinterface

// File: rtl/dt_tree_engine_node_mem.sv
// Node table: register file with one write port and one combinational read port.
module dt_tree_engine_node_mem #(
   parameter int NUM_NODES = 32,
   parameter int WORD_W    = 29,
   parameter int ADDR_W    = $clog2(NUM_NODES)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [WORD_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [WORD_W-1:0] rdata
);

   logic [WORD_W-1:0] mem [NUM_NODES];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/dt_tree_engine.sv
// Decision-tree walker: shadows the feature vector on start, then evaluates one node per
// clock from the run-time node table until a leaf, a bad feature index or the depth limit.
module dt_tree_engine
   import dt_tree_engine_pkg::*;
#(
   parameter int NUM_FEAT  = DEF_NUM_FEAT,
   parameter int FEAT_W    = DEF_FEAT_W,
   parameter int NUM_NODES = DEF_NUM_NODES,
   parameter int CLASS_W   = DEF_CLASS_W,
   parameter int MAX_DEPTH = DEF_MAX_DEPTH
) (
   input  logic            clk,
   input  logic            rst_n,
   dt_tree_engine_if.slave bus
);

   localparam int FIDX_W    = $clog2(NUM_FEAT);
   localparam int NODE_W    = $clog2(NUM_NODES);
   localparam int WORD_W    = 1 + FIDX_W + FEAT_W + 2 * NODE_W;
   localparam int DEPTH_W   = $clog2(MAX_DEPTH + 1);
   localparam int LEFT_LSB  = NODE_W;
   localparam int THR_LSB   = 2 * NODE_W;
   localparam int FIDX_LSB  = THR_LSB + FEAT_W;
   localparam int LEAF_POS  = FIDX_LSB + FIDX_W;
   localparam logic [DEPTH_W-1:0] CNT_LAST = DEPTH_W'(MAX_DEPTH - 1);

   state_t             state, state_nxt;
   logic [NODE_W-1:0]  node, node_nxt;
   logic [DEPTH_W-1:0] cnt, cnt_nxt;
   logic [CLASS_W-1:0] class_q, class_nxt;
   logic               err_q, err_nxt;
   logic [DEPTH_W-1:0] depth_q, depth_nxt;
   logic               cfg_err_q;
   logic               accept;
   logic               mem_we;
   logic [WORD_W-1:0]  word;
   logic [FEAT_W-1:0]  feat_shadow [NUM_FEAT];

   logic               w_leaf;
   logic [FIDX_W-1:0]  w_fidx;
   logic [FEAT_W-1:0]  w_thr;
   logic [NODE_W-1:0]  w_left;
   logic [NODE_W-1:0]  w_right;
   logic               fidx_bad;
   logic [FEAT_W-1:0]  feat_sel;
   logic [NODE_W-1:0]  child;

   assign accept = (state == ST_IDLE) && bus.start;
   // Table writes are only honoured while idle, so a walk never sees a word change under it.
   assign mem_we = bus.cfg_we && (state == ST_IDLE);

   dt_tree_engine_node_mem #(
      .NUM_NODES (NUM_NODES),
      .WORD_W    (WORD_W)
   ) u_node_mem (
      .clk   (clk),
      .we    (mem_we),
      .waddr (bus.cfg_addr),
      .wdata (bus.cfg_data),
      .raddr (node),
      .rdata (word)
   );

   assign w_leaf   = word[LEAF_POS];
   assign w_fidx   = word[FIDX_LSB +: FIDX_W];
   assign w_thr    = word[THR_LSB +: FEAT_W];
   assign w_left   = word[LEFT_LSB +: NODE_W];
   assign w_right  = word[NODE_W-1:0];
   assign fidx_bad = {1'b0, w_fidx} >= (FIDX_W + 1)'(NUM_FEAT);
   assign feat_sel = fidx_bad ? '0 : feat_shadow[w_fidx];
   assign child    = (feat_sel <= w_thr) ? w_left : w_right;

   always_comb begin
      state_nxt = state;
      node_nxt  = node;
      cnt_nxt   = cnt;
      class_nxt = class_q;
      err_nxt   = err_q;
      depth_nxt = depth_q;
      case (state)
         ST_IDLE: begin
            if (bus.start) begin
               state_nxt = ST_WALK;
               node_nxt  = '0;
               cnt_nxt   = '0;
            end
         end
         ST_WALK: begin
            if (w_leaf) begin
               class_nxt = w_thr[CLASS_W-1:0];
               err_nxt   = 1'b0;
               depth_nxt = cnt + 1'b1;
               state_nxt = ST_DONE;
            end else if (fidx_bad || (cnt == CNT_LAST)) begin
               err_nxt   = 1'b1;
               depth_nxt = cnt + 1'b1;
               state_nxt = ST_DONE;
            end else begin
               node_nxt  = child;
               cnt_nxt   = cnt + 1'b1;
            end
         end
         ST_DONE: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         node      <= '0;
         cnt       <= '0;
         class_q   <= '0;
         err_q     <= 1'b0;
         depth_q   <= '0;
         cfg_err_q <= 1'b0;
      end else begin
         state     <= state_nxt;
         node      <= node_nxt;
         cnt       <= cnt_nxt;
         class_q   <= class_nxt;
         err_q     <= err_nxt;
         depth_q   <= depth_nxt;
         cfg_err_q <= bus.cfg_we && (state != ST_IDLE);
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         for (int i = 0; i < NUM_FEAT; i++) begin
            feat_shadow[i] <= bus.features[i*FEAT_W +: FEAT_W];
         end
      end
   end

   assign bus.ready        = (state == ST_IDLE);
   assign bus.result_valid = (state == ST_DONE);
   assign bus.class_out    = class_q;
   assign bus.err_out      = err_q;
   assign bus.depth_out    = depth_q;
   assign bus.cfg_err      = cfg_err_q;

endmodule

// File: tb/tb_dt_tree_engine.sv
// Randomised scoreboard bench for dt_tree_engine against a node-array tree-walk reference model.
module tb_dt_tree_engine;
   import dt_tree_engine_pkg::*;

   localparam int NF = DEF_NUM_FEAT;
   localparam int FW = DEF_FEAT_W;
   localparam int NN = DEF_NUM_NODES;
   localparam int MD = DEF_MAX_DEPTH;

   typedef logic [NF*FW-1:0] feat_t;
   typedef struct {
      int cls;
      int err;
      int depth;
      int cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_errors = 0;

   logic m_leaf [NN];
   int   m_fidx [NN];
   int   m_thr  [NN];
   int   m_left [NN];
   int   m_right[NN];
   int   last_class = 0;
   exp_t sb_q[$];

   dt_tree_engine_if bus ();

   dt_tree_engine dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic feat_t rand_feat();
      feat_t f;
      for (int i = 0; i < NF; i++) f[i*FW +: FW] = FW'($urandom_range(0, (1 << FW) - 1));
      return f;
   endfunction

   // Reference: follow the tree from the root, counting visited nodes.
   function automatic void model_walk(input feat_t f, output int cls, output int err,
                                      output int depth);
      int n = 0;
      cls   = last_class;
      err   = 1;
      depth = MD;
      for (int visit = 1; visit <= MD; visit++) begin
         if (m_leaf[n]) begin
            cls   = m_thr[n] % (1 << DEF_CLASS_W);
            err   = 0;
            depth = visit;
            return;
         end
         if (m_fidx[n] >= NF) begin
            depth = visit;
            return;
         end
         n = (int'(f[m_fidx[n]*FW +: FW]) <= m_thr[n]) ? m_left[n] : m_right[n];
      end
   endfunction

   task automatic model_write(input int a, input logic leaf, input int fidx, input int thr,
                              input int l, input int r);
      m_leaf[a] = leaf; m_fidx[a] = fidx; m_thr[a] = thr; m_left[a] = l; m_right[a] = r;
   endtask

   task automatic drive_cfg(input int a, input logic leaf, input int fidx, input int thr,
                            input int l, input int r);
      bus.cfg_we   = 1'b1;
      bus.cfg_addr = DT_NODE_W'(a);
      bus.cfg_data = pack_node(leaf, DT_FIDX_W'(fidx), DEF_FEAT_W'(thr), DT_NODE_W'(l),
                               DT_NODE_W'(r));
   endtask

   task automatic cfg_write(input int a, input logic leaf, input int fidx, input int thr,
                            input int l, input int r);
      int busy;
      busy = bus.ready ? 0 : 1;
      drive_cfg(a, leaf, fidx, thr, l, r);
      if (busy == 0) model_write(a, leaf, fidx, thr, l, r);
      @(negedge clk);
      bus.cfg_we = 1'b0;
      check("cfg_err", bus.cfg_err, busy);
   endtask

   // Called on a negedge; returns on the negedge after the accepting edge.
   task automatic issue(input feat_t f, input bit hold, output int d, output int t_acc);
      int cls, err, n;
      bus.start = 1'b1;
      n = 0;
      while (!bus.ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!bus.ready) begin
         check("ready_timeout", 0, 1);
         bus.start = 1'b0;
         d = 0;
         t_acc = 0;
         return;
      end
      bus.features = f;
      model_walk(f, cls, err, d);
      if (err == 0) last_class = cls;
      t_acc = cyc + 1;
      sb_q.push_back('{cls: cls, err: err, depth: d, cyc: t_acc + d});
      @(negedge clk);
      bus.features = rand_feat();
      if (!hold) bus.start = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (sb_q.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (sb_q.size() != 0) begin
         check("drain_timeout", sb_q.size(), 0);
         sb_q.delete();
      end
      @(negedge clk);
   endtask

   task automatic load_t1_tree();
      cfg_write(0, 1'b0, 38, 16, 1, 2);
      cfg_write(1, 1'b0, 39, 10, 3, 4);
      cfg_write(2, 1'b1, 0, 1, 0, 0);
      cfg_write(3, 1'b0, 0, 1638, 5, 6);
      cfg_write(4, 1'b0, 34, 4, 5, 6);
      cfg_write(5, 1'b1, 0, 0, 0, 0);
      cfg_write(6, 1'b1, 0, 1, 0, 0);
   endtask

   task automatic load_loop_tree();
      cfg_write(0, 1'b0, 0, 4095, 1, 1);
      cfg_write(1, 1'b0, 5, 100, 0, 0);
   endtask

   always @(negedge clk) begin
      if (rst_n && bus.result_valid) begin
         if (sb_q.size() == 0) begin
            check("unexpected_result", 1, 0);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            check("class_out", bus.class_out, e.cls);
            check("err_out", bus.err_out, e.err);
            check("depth_out", bus.depth_out, e.depth);
            check("result_cycle", cyc, e.cyc);
            check("ready_in_done", bus.ready, 0);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      feat_t f, f2, f3;
      int d1, d2, d3, t1, t2, t3;
      rst_n        = 1'b1;
      bus.cfg_we   = 1'b0;
      bus.cfg_addr = '0;
      bus.cfg_data = '0;
      bus.start    = 1'b0;
      bus.features = '0;
      #2 rst_n = 1'b0;
      #1;
      check("rst_ready", bus.ready, 1);
      check("rst_result_valid", bus.result_valid, 0);
      check("rst_class", bus.class_out, 0);
      check("rst_err", bus.err_out, 0);
      check("rst_depth", bus.depth_out, 0);
      check("rst_cfg_err", bus.cfg_err, 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // T1 / T2: reference tree, right branch and both sides of the <= boundary.
      load_t1_tree();
      f = rand_feat(); f[38*FW +: FW] = 12'd20;
      issue(f, 1'b0, d1, t1);
      drain();
      f = rand_feat(); f[38*FW +: FW] = 12'd16; f[39*FW +: FW] = 12'd10; f[0 +: FW] = 12'd1638;
      issue(f, 1'b0, d1, t1);
      drain();
      f[0 +: FW] = 12'd1639;
      issue(f, 1'b0, d1, t1);
      drain();

      // T4: write during a walk is rejected; walk and later walks use the old table.
      f[0 +: FW] = 12'd1638;
      issue(f, 1'b0, d1, t1);
      cfg_write(5, 1'b1, 0, 3, 0, 0);
      drain();
      issue(f, 1'b0, d1, t1);
      drain();
      // Same-cycle write and start: the walk sees the new word.
      check("ready_before_wr", bus.ready, 1);
      drive_cfg(2, 1'b1, 0, 2, 0, 0);
      model_write(2, 1'b1, 0, 2, 0, 0);
      f = rand_feat(); f[38*FW +: FW] = 12'd20;
      issue(f, 1'b0, d1, t1);
      bus.cfg_we = 1'b0;
      drain();
      cfg_write(2, 1'b1, 0, 1, 0, 0);

      // T5: start held high across three walks; features scrambled after each accept.
      f  = rand_feat(); f[38*FW +: FW] = 12'd20;
      f2 = rand_feat(); f2[38*FW +: FW] = 12'd0; f2[39*FW +: FW] = 12'd0; f2[0 +: FW] = 12'd0;
      f3 = rand_feat(); f3[38*FW +: FW] = 12'd0; f3[39*FW +: FW] = 12'd11;
      f3[34*FW +: FW] = 12'd5;
      issue(f, 1'b1, d1, t1);
      issue(f2, 1'b1, d2, t2);
      issue(f3, 1'b0, d3, t3);
      check("b2b_period_1", t2 - t1, d1 + 2);
      check("b2b_period_2", t3 - t2, d2 + 2);
      drain();

      // T3: non-leaf cycle aborts at the depth limit, class held.
      load_loop_tree();
      issue(rand_feat(), 1'b0, d1, t1);
      drain();

      // Random tables and feature vectors.
      for (int tbl = 0; tbl < 5; tbl++) begin
         for (int a = 0; a < NN; a++) begin
            logic lf;
            int   l, r;
            lf = (a == NN - 1) || ($urandom_range(0, 2) == 0);
            l  = (a < NN - 1) ? $urandom_range(NN - 1, a + 1) : 0;
            r  = (a < NN - 1) ? $urandom_range(NN - 1, a + 1) : 0;
            if ($urandom_range(0, 9) == 0) l = $urandom_range(0, NN - 1);
            cfg_write(a, lf, $urandom_range(0, NF - 1), $urandom_range(0, (1 << FW) - 1), l, r);
         end
         for (int k = 0; k < 8; k++) begin
            issue(rand_feat(), bit'($urandom_range(0, 1)), d1, t1);
         end
         bus.start = 1'b0;
         drain();
      end

      // T6: reset in the middle of a walk with non-zero class and err pending.
      load_t1_tree();
      f = rand_feat(); f[38*FW +: FW] = 12'd20;
      issue(f, 1'b0, d1, t1);
      drain();
      load_loop_tree();
      issue(rand_feat(), 1'b0, d1, t1);
      drain();
      issue(rand_feat(), 1'b0, d1, t1);
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      #1;
      sb_q.delete();
      last_class = 0;
      check("midrst_ready", bus.ready, 1);
      check("midrst_result_valid", bus.result_valid, 0);
      check("midrst_class", bus.class_out, 0);
      check("midrst_err", bus.err_out, 0);
      check("midrst_depth", bus.depth_out, 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (30) @(negedge clk);
      check("post_rst_ready", bus.ready, 1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
